// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte sources.
// Optional tx_busy timeout with sticky err flag: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N   = 4,
  parameter int IW  = 2,
  parameter int TMO = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [8*N-1:0]   data_in,
  output logic [N-1:0]     grant,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  output logic [IW-1:0]    owner,
  output logic             active,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  if (N < 2 || N > 8 || (2 ** IW) < N || TMO < 1) begin : g_bad_param
    $error("uart_tx_arbiter: illegal parameter combination");
  end

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            active_q, active_d;
  logic            pick_found_s;
  logic [IW-1:0]   pick_idx_s;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);
  logic [15:0]     tmo_cnt_q, tmo_cnt_d;
  logic            err_q, err_d;
`endif

  // Successor index with wrap at N rather than at 2**IW.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    logic [IW-1:0] res;
    if (int'(i) == N - 1) begin
      res = '0;
    end else begin
      res = i + IW'(1);
    end
    return res;
  endfunction

  // Scan from the lowest offset last so it wins: first requester at or after p.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW:0] res;
    int          j;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= N) begin
        j = j - N;
      end
      if ((r & (N'(1) << j)) != '0) begin
        res = {1'b1, IW'(j)};
      end
    end
    return res;
  endfunction

  assign {pick_found_s, pick_idx_s} = rr_pick(req, ptr_q);

  // Next-state and registered-output logic for the arbitration FSM.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    owner_d    = owner_q;
`ifdef UART_ARB_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_found_s) begin
          tx_data_d  = 8'(data_in >> (32'd8 * 32'(pick_idx_s)));
          owner_d    = pick_idx_s;
          grant_d    = N'(1) << pick_idx_s;
          tx_start_d = 1'b1;
          state_d    = S_WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
          tmo_cnt_d  = 16'd0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          ptr_d   = next_idx(owner_q);
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`else
        else begin
          state_d = S_WAIT_BUSY;
        end
`endif
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          ptr_d   = next_idx(owner_q);
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    active_d = (state_d != S_IDLE);
  end

  // State and output registers; synchronous reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      owner_q    <= '0;
      active_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt_q  <= 16'd0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      owner_q    <= owner_d;
      active_q   <= active_d;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign owner    = owner_q;
  assign active   = active_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter between N byte sources.
- Picks one requester and latches its byte.
- Issues a one-cycle start pulse to the transmitter, then waits for the transmitter's busy flag to rise and fall before serving the next requester.
- Sits between the packet and debug producers and the single uart_tx/baud-counter datapath.

Parameters:
N, 4, number of requesters (2..8)
IW, 2, width of owner index; must satisfy 2**IW >= N
TMO, 2048, clock cycles to wait for tx_busy to rise after tx_start (used only with the optional feature)

Ports:
clk  input  1  system clock
rst  input  1  reset (synchronous, active-high)
req  input  N  per-requester "byte pending"; level; must stay high until the matching grant bit pulses
data_in  input  8*N  byte of requester i on data_in[8*i+7:8*i]
grant  output  N  one-cycle one-hot pulse; the byte of that requester has been taken
tx_data  output  8  byte presented to the transmitter; held stable from tx_start until the return to IDLE
tx_start  output  1  one-cycle start pulse to the transmitter
tx_busy  input  1  transmitter busy (high from start until the stop bit ends)
owner  output  IW  index of the current or last granted requester
active  output  1  high in every state other than IDLE
err  output  1  timeout sticky flag (optional feature only; otherwise tied 0)

Behaviour:
- All state is updated on posedge clk. Synchronous rst has priority over everything and may arrive at any time, including mid-transfer.
- Reset values: state = IDLE, ptr = 0, grant = 0, tx_start = 0, tx_data = 8'h00, owner = 0, active = 0, err = 0.
- Reset mid-transfer abandons the byte. Its requester keeps req high and is re-arbitrated after reset.
- States:
  - IDLE: if req != 0, select the first i with req[i] = 1, scanning ptr, ptr+1, ... with wrap mod N. In the same clock edge: tx_data <= data_in[i], owner <= i, grant <= one-hot(i), tx_start <= 1, state <= WAIT_BUSY. If req == 0, stay in IDLE.
  - WAIT_BUSY: grant and tx_start return to 0 (exactly one-cycle pulses). When tx_busy = 1, go to WAIT_DONE.
  - WAIT_DONE: when tx_busy = 0, set ptr <= (owner+1) mod N and go to IDLE.
- Latency: req[i] sampled high in IDLE at edge k gives tx_start = 1 and grant[i] = 1 during cycle k+1.
- Minimum spacing between tx_start pulses: 3 cycles plus the transmitter busy time. Back-to-back requests never overlap.
- Fairness: with all N requesting continuously, grants rotate 0,1,...,N-1,0. No requester waits more than N-1 transfers.
- Simultaneous events:
  - A req deasserting in the same cycle the arbiter is in IDLE is not granted if sampled low.
  - A req change on a non-owner during WAIT_* has no effect.
  - req[owner] may stay high after its grant: a second byte from the same source is queued fairly behind the others.
- tx_busy already high in IDLE (stale transmitter) is ignored.
- In WAIT_BUSY, tx_busy high on the first cycle transitions immediately.
- data_in must be valid while req is high. Only the value at the grant edge is used.
- The ptr wrap arithmetic is mod N, not mod 2**IW. For N = 3, ptr after owner 2 is 0.

Optional Feature:
Macro UART_ARB_TIMEOUT_EN.
- Defined: an IW-independent 16-bit counter runs in WAIT_BUSY.
  - If tx_busy is not seen high within TMO cycles of entering WAIT_BUSY, set err (sticky until rst) and go to IDLE with ptr <= owner+1 mod N.
  - The lost byte is not retried (grant was already given).
  - WAIT_DONE has no timeout.
- Not defined: no counter is built, err is tied to 0, and WAIT_BUSY waits indefinitely.

Test Plan:
- Single request: rst for 2 cycles, then req = 4'b0100 with data_in byte2 = 8'hA5. Response: tx_start and grant = 4'b0100 one cycle later, tx_data = 8'hA5, owner = 2. A transmitter model busy for 10 cycles returns to IDLE and ptr = 3.
- Round-robin: req = 4'b1111 held, bytes 8'h10/8'h11/8'h12/8'h13. Response: tx_data sequence 10,11,12,13,10. Each grant is a one-cycle pulse, and exactly one tx_start per busy window.
- Wrap with N = 3: ptr = 2, req = 3'b011. Response: grant requester 0 first, then 1.
- Reset mid-transfer: rst asserted while in WAIT_DONE with tx_busy = 1. Response: next cycle all outputs are at reset values. With req = 4'b0010 held, the byte is re-granted after rst is released.
- Stale busy: tx_busy = 1 constant during IDLE with req = 0. Response: no tx_start. Then req = 4'b0001 gives tx_start the next cycle and an immediate move to WAIT_DONE.
- Timeout (UART_ARB_TIMEOUT_EN, TMO = 8): tx_busy held 0 after tx_start. Response: err = 1 after 8 cycles in WAIT_BUSY, return to IDLE, and the next requester is served. err stays 1 until rst.
